// File: rtl/pwm_timebase_counter_if.sv
// Control and status bundle between the register file/prescaler (master) and
// the PWM time-base counter (slave).
interface pwm_timebase_counter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 cen_i;
    logic                 ck_cnt_i;
    logic [CNT_WIDTH-1:0] arr_preload_i;
    logic                 arpe_i;
    logic                 dir_i;
    logic [1:0]           cms_i;
    logic                 opm_i;
    logic                 udis_i;
    logic                 ug_i;
    logic                 uif_clr_i;
    logic [CNT_WIDTH-1:0] cnt_o;
    logic [CNT_WIDTH-1:0] arr_active_o;
    logic                 dir_o;
    logic                 update_event_o;
    logic                 uif_o;
    logic                 cen_clr_o;

    modport master (
        output cen_i, ck_cnt_i, arr_preload_i, arpe_i, dir_i, cms_i, opm_i,
               udis_i, ug_i, uif_clr_i,
        input  cnt_o, arr_active_o, dir_o, update_event_o, uif_o, cen_clr_o
    );

    modport slave (
        input  cen_i, ck_cnt_i, arr_preload_i, arpe_i, dir_i, cms_i, opm_i,
               udis_i, ug_i, uif_clr_i,
        output cnt_o, arr_active_o, dir_o, update_event_o, uif_o, cen_clr_o
    );
endinterface

// File: rtl/pwm_timebase_counter.sv
// PWM time-base counter: edge/center-aligned counting against an auto-reload
// value, update event generation, sticky update flag and one-pulse stop.
module pwm_timebase_counter #(
    parameter int CNT_WIDTH = 16
) (
    input logic                   clk_psc_i,
    input logic                   rst_i,
    pwm_timebase_counter_if.slave tmr
);
    localparam int W = CNT_WIDTH;
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic         dir_q, dir_d;
    logic         uev_q, uev_d;
    logic         uif_q, uif_d;
    logic         cen_clr_q, cen_clr_d;
    logic         opm_stop_q, opm_stop_d;

    logic [W-1:0] arr_active;
    logic [W-1:0] next_arr;
    logic [W:0]   cnt_inc;
    logic         tick;
    logic         edge_mode;
    logic         down_mode;
    logic         wrap_evt;

    assign arr_active = tmr.arpe_i ? shadow_q : tmr.arr_preload_i;

    always_comb begin
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        wrap_evt   = 1'b0;
        tick       = tmr.cen_i & tmr.ck_cnt_i & ~opm_stop_q;
        edge_mode  = (tmr.cms_i == 2'b00);
        down_mode  = edge_mode & dir_q;
        cnt_inc    = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
        // The shadow only loads on an underflow edge when the event is not suppressed.
        next_arr   = tmr.udis_i ? arr_active : tmr.arr_preload_i;

        if (tmr.ug_i) begin
            if (down_mode) begin
                cnt_d = tmr.arr_preload_i;
            end else begin
                cnt_d = '0;
                dir_d = edge_mode ? tmr.dir_i : 1'b0;
            end
        end else if (tick) begin
            if (edge_mode) begin
                if (!dir_q) begin
                    if (cnt_q >= arr_active) begin
                        cnt_d    = '0;
                        wrap_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[W-1:0];
                    end
                end else begin
                    if (cnt_q == '0) begin
                        cnt_d    = next_arr;
                        wrap_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end else if (arr_active == '0) begin
                cnt_d = '0;
            end else if (!dir_q) begin
                if (cnt_inc >= {1'b0, arr_active}) begin
                    cnt_d    = arr_active;
                    dir_d    = 1'b1;
                    wrap_evt = tmr.cms_i[1];
                end else begin
                    cnt_d = cnt_inc[W-1:0];
                end
            end else begin
                if (cnt_q <= CNT_ONE) begin
                    cnt_d    = '0;
                    dir_d    = 1'b0;
                    wrap_evt = tmr.cms_i[0];
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end

        if (!tmr.cen_i) begin
            dir_d = edge_mode ? tmr.dir_i : 1'b0;
        end

        uev_d     = (tmr.ug_i | wrap_evt) & ~tmr.udis_i;
        cen_clr_d = wrap_evt & tmr.opm_i & ~tmr.udis_i;
        shadow_d  = (!tmr.cen_i || uev_d) ? tmr.arr_preload_i : shadow_q;
        uif_d     = uev_d ? 1'b1 : (tmr.uif_clr_i ? 1'b0 : uif_q);

        if (!tmr.cen_i) begin
            opm_stop_d = 1'b0;
        end else if (cen_clr_d) begin
            opm_stop_d = 1'b1;
        end else begin
            opm_stop_d = opm_stop_q;
        end
    end

    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            shadow_q   <= '0;
            dir_q      <= 1'b0;
            uev_q      <= 1'b0;
            uif_q      <= 1'b0;
            cen_clr_q  <= 1'b0;
            opm_stop_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            dir_q      <= dir_d;
            uev_q      <= uev_d;
            uif_q      <= uif_d;
            cen_clr_q  <= cen_clr_d;
            opm_stop_q <= opm_stop_d;
        end
    end

    assign tmr.cnt_o          = cnt_q;
    assign tmr.arr_active_o   = arr_active;
    assign tmr.dir_o          = dir_q;
    assign tmr.update_event_o = uev_q;
    assign tmr.uif_o          = uif_q;
    assign tmr.cen_clr_o      = cen_clr_q;
endmodule
